// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: accumulates psums over several passes, then drains them on a stream.
// Optional macro PSUM_SAT_EN selects a signed saturating accumulate instead of a wrap-around add.
module psum_acc_buf #(
  parameter int PSUM_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int PASS_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_W-1:0]      cfg_len_m1,
  input  logic [PASS_W-1:0]     cfg_pass_m1,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_psum,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic [IDX_W-1:0]      wr_idx_reg;
  logic [IDX_W-1:0]      rd_idx_reg;
  logic [IDX_W-1:0]      len_m1_reg;
  logic [PASS_W-1:0]     pass_cnt_reg;
  logic [PASS_W-1:0]     pass_m1_reg;
  logic                  done_reg;
  logic [PSUM_WIDTH-1:0] acc_mem [DEPTH];

  logic                  in_fire;
  logic                  out_fire;
  logic                  wr_last_entry;
  logic                  wr_last_pass;
  logic                  rd_last_entry;
  logic [PSUM_WIDTH-1:0] addend;
  logic [PSUM_WIDTH-1:0] wr_data;

  assign in_fire       = in_valid && (state_reg == ACC);
  assign out_fire      = out_ready && (state_reg == DRAIN);
  assign wr_last_entry = (wr_idx_reg == len_m1_reg);
  assign wr_last_pass  = (pass_cnt_reg == pass_m1_reg);
  assign rd_last_entry = (rd_idx_reg == len_m1_reg);

  // Pass 0 overwrites, so stale contents from a previous job never leak in.
  assign addend = (pass_cnt_reg == '0) ? '0 : acc_mem[wr_idx_reg];

`ifdef PSUM_SAT_EN
  logic [PSUM_WIDTH:0] sum_ext;
  assign sum_ext = {addend[PSUM_WIDTH-1], addend} + {in_psum[PSUM_WIDTH-1], in_psum};

  always_comb begin
    wr_data = sum_ext[PSUM_WIDTH-1:0];
    if (sum_ext[PSUM_WIDTH] != sum_ext[PSUM_WIDTH-1]) begin
      wr_data = sum_ext[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    end
  end
`else
  assign wr_data = addend + in_psum;
`endif

  // Storage carries no reset; every job rewrites its entries on pass 0.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      acc_mem[wr_idx_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      len_m1_reg   <= '0;
      pass_cnt_reg <= '0;
      pass_m1_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= out_fire && rd_last_entry;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_m1_reg   <= cfg_len_m1;
            pass_m1_reg  <= cfg_pass_m1;
            wr_idx_reg   <= '0;
            pass_cnt_reg <= '0;
            state_reg    <= ACC;
          end
        end
        ACC: begin
          if (in_fire) begin
            if (wr_last_entry) begin
              wr_idx_reg   <= '0;
              pass_cnt_reg <= pass_cnt_reg + 1'b1;
              if (wr_last_pass) begin
                rd_idx_reg <= '0;
                state_reg  <= DRAIN;
              end
            end else begin
              wr_idx_reg <= wr_idx_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
            if (rd_last_entry) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so reset forces them low without a clock.
  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == DRAIN);
  assign out_last  = (state_reg == DRAIN) && rd_last_entry;
  assign out_psum  = (state_reg == DRAIN) ? acc_mem[rd_idx_reg] : '0;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Randomized, self-checking bench for psum_acc_buf against a per-entry arithmetic reference model.
module tb_psum_acc_buf;
  localparam int W      = 32;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PASS_W = 8;
  localparam int MAXP   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] cfg_len_m1 = '0;
  logic [PASS_W-1:0] cfg_pass_m1 = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_psum = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_psum;
  logic             out_last;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_count;

  logic [W-1:0] stim  [MAXP][DEPTH];
  logic [W-1:0] exp_v [DEPTH];

  psum_acc_buf #(.PSUM_WIDTH(W), .DEPTH(DEPTH), .IDX_W(IDX_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len_m1(cfg_len_m1),
    .cfg_pass_m1(cfg_pass_m1), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed add of two W-bit values, wrapped or clamped depending on the build.
  function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[W-1:0];
  endfunction

  function automatic void compute_exp(input int len, input int np);
    for (int i = 0; i <= len; i++) begin
      logic [W-1:0] acc;
      acc = stim[0][i];
      for (int p = 1; p <= np; p++) acc = acc_add(acc, stim[p][i]);
      exp_v[i] = acc;
    end
  endfunction

  task automatic start_job(input int len, input int np);
    start = 1'b1;
    cfg_len_m1 = IDX_W'(len);
    cfg_pass_m1 = PASS_W'(np);
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_in_ready", 64'(in_ready), 64'(1));
  endtask

  // Sends every psum of the job back-to-back; optionally pokes start mid-job.
  task automatic feed(input int len, input int np, input bit poke_start);
    for (int p = 0; p <= np; p++) begin
      for (int i = 0; i <= len; i++) begin
        in_valid = 1'b1;
        in_psum  = stim[p][i];
        if (poke_start && p == 0 && i == 1) begin
          start = 1'b1;
          cfg_len_m1 = '0;
          cfg_pass_m1 = '0;
        end
        chk("acc_in_ready", 64'(in_ready), 64'(1));
        chk("acc_out_valid", 64'(out_valid), 64'(0));
        tick();
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int len, input bit rnd_ready, output int hs);
    int cycles;
    bit stalled;
    logic [W-1:0] held_psum;
    logic held_last;
    hs = 0;
    cycles = 0;
    stalled = 1'b0;
    held_psum = '0;
    held_last = 1'b0;
    while (hs <= len && cycles < 2000) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_psum   = $urandom;
      chk("drain_out_valid", 64'(out_valid), 64'(1));
      chk("drain_in_ready", 64'(in_ready), 64'(0));
      chk("drain_psum", 64'(out_psum), 64'(exp_v[hs]));
      chk("drain_last", 64'(out_last), 64'(hs == len));
      if (stalled) begin
        chk("stall_psum_stable", 64'(out_psum), 64'(held_psum));
        chk("stall_last_stable", 64'(out_last), 64'(held_last));
      end
      stalled   = !out_ready;
      held_psum = out_psum;
      held_last = out_last;
      tick();
      if (out_ready) hs++;
      cycles++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_handshakes", 64'(hs), 64'(len + 1));
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy_low", 64'(busy), 64'(0));
  endtask

  task automatic run_job(input int len, input int np, input bit rnd_ready);
    compute_exp(len, np);
    start_job(len, np);
    feed(len, np, 1'b0);
    drain(len, rnd_ready, hs_count);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_psum", 64'(out_psum), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // in_valid while idle must not handshake
    in_valid = 1'b1;
    in_psum  = 32'hDEAD_BEEF;
    chk("idle_in_ready", 64'(in_ready), 64'(0));
    tick();
    in_valid = 1'b0;
    chk("idle_busy", 64'(busy), 64'(0));

    // Basic accumulate
    for (int i = 0; i < 4; i++) begin
      stim[0][i] = W'(i + 1);
      stim[1][i] = W'(10 * (i + 1));
    end
    compute_exp(3, 1);
    chk("basic_model_0", 64'(exp_v[0]), 64'(11));
    chk("basic_model_3", 64'(exp_v[3]), 64'(44));
    run_job(3, 1, 1'b0);
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));

    // Single pass, then back-to-back start in the done cycle
    stim[0][0] = -32'sd5;
    compute_exp(0, 0);
    start_job(0, 0);
    feed(0, 0, 1'b0);
    drain(0, 1'b0, hs_count);
    stim[0][0] = 32'd7;
    compute_exp(0, 0);
    start_job(0, 0);
    feed(0, 0, 1'b0);
    drain(0, 1'b0, hs_count);

    // Backpressure: 16 entries, 3 passes of 1
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < DEPTH; i++) stim[p][i] = 32'd1;
    compute_exp(15, 2);
    chk("bp_model", 64'(exp_v[15]), 64'(3));
    start_job(15, 2);
    feed(15, 2, 1'b0);
    drain(15, 1'b1, hs_count);
    chk("bp_16_handshakes", 64'(hs_count), 64'(16));
    tick();

    // Overflow / underflow
    stim[0][0] = 32'h7FFF_FFFF; stim[1][0] = 32'h0000_0001;
    stim[0][1] = 32'h8000_0000; stim[1][1] = 32'hFFFF_FFFF;
    compute_exp(1, 1);
`ifdef PSUM_SAT_EN
    chk("ovf_model", 64'(exp_v[0]), 64'(32'h7FFF_FFFF));
    chk("unf_model", 64'(exp_v[1]), 64'(32'h8000_0000));
`else
    chk("ovf_model", 64'(exp_v[0]), 64'(32'h8000_0000));
    chk("unf_model", 64'(exp_v[1]), 64'(32'h7FFF_FFFF));
`endif
    run_job(1, 1, 1'b0);
    tick();

    // start during ACC is ignored
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++) stim[p][i] = $urandom;
    compute_exp(4, 1);
    start_job(4, 1);
    feed(4, 1, 1'b1);
    drain(4, 1'b1, hs_count);
    tick();

    // Reset in the middle of pass 1
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) stim[p][i] = $urandom;
    start_job(3, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_psum  = stim[i / 4][i % 4];
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_last", 64'(out_last), 64'(0));
    chk("mid_rst_out_psum", 64'(out_psum), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) stim[p][i] = $urandom;
    run_job(3, 1, 1'b0);
    tick();

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      int len;
      int np;
      len = $urandom_range(0, DEPTH - 1);
      np  = $urandom_range(0, MAXP - 1);
      for (int p = 0; p <= np; p++)
        for (int i = 0; i <= len; i++) stim[p][i] = $urandom;
      run_job(len, np, 1'b1);
      if (j % 2 == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_acc_buf.md
# psum_acc_buf

Partial-sum accumulation buffer for the differential NN core. It sits directly downstream of the PSUM_WIDTH adder and closes the loop around it. Each incoming partial sum is added to the stored entry for its output position, over a configured number of passes. When all passes are done, the accumulated vector is drained to the next stage over a valid/ready stream. Storage is a register file of DEPTH entries.

## Interface
- PSUM_WIDTH, 32, partial-sum width; matches the core package value
- DEPTH, 16, number of accumulator entries (power of two, ≥2)
- IDX_W, $clog2(DEPTH), entry index width
- PASS_W, 8, pass counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a job; sampled only in IDLE
- cfg_len_m1  in  IDX_W  entries per pass minus 1; sampled at accepted start
- cfg_pass_m1  in  PASS_W  passes minus 1; sampled at accepted start
- in_valid  in  1  in_psum valid
- in_ready  out  1  block accepts in_psum
- in_psum  in  PSUM_WIDTH  incoming partial sum, two's complement
- out_valid  out  1  out_psum valid
- out_ready  in  1  downstream accepts
- out_psum  out  PSUM_WIDTH  accumulated result
- out_last  out  1  marks the final drained entry
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the final drain handshake

## Operation
- FSM states: IDLE, ACC, DRAIN.
- **IDLE**
  - start=1 latches cfg_len_m1 and cfg_pass_m1, clears wr_idx and pass_cnt, then moves to ACC.
  - Buffer contents are not cleared.
- **ACC**
  - in_ready=1. Each in_valid&in_ready handshake updates buf[wr_idx].
  - On pass 0 the entry is written with in_psum (addend forced to 0).
  - On later passes the entry becomes buf[wr_idx] + in_psum.
  - wr_idx increments. At wr_idx==len_m1 it wraps to 0 and pass_cnt increments.
  - The handshake at wr_idx==len_m1 with pass_cnt==pass_m1 moves the FSM to DRAIN and clears rd_idx.
- **DRAIN**
  - in_ready=0. out_valid=1. out_psum=buf[rd_idx]. out_last=(rd_idx==len_m1).
  - On out_valid&out_ready, rd_idx increments.
  - The handshake with out_last=1 moves the FSM to IDLE and pulses done on the next cycle.
- Arithmetic: full PSUM_WIDTH add, result truncated modulo 2^PSUM_WIDTH (see Configuration).
- start outside IDLE is ignored. in_valid outside ACC is ignored (no handshake).
- Reset mid-job: the FSM returns to IDLE immediately and the job is lost. Buffer contents need not be reset.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_psum=0, busy=0, done=0. Also state=IDLE, all counters 0.
- start accepted at cycle T: busy=1 and in_ready=1 from T+1.
- ACC throughput is one psum per cycle; no input-side bubbles.
- The written entry is visible to the drain on the cycle after its write. The last ACC handshake at cycle T gives out_valid=1 at T+1.
- DRAIN throughput is one entry per cycle while out_ready=1.
- While out_ready=0, out_psum and out_last stay stable.
- done=1 at the cycle after the final drain handshake, together with busy=0.
- A new start is accepted in that same cycle.
- All outputs are registered, or decoded from registered state and the buffer only; there are no combinational paths from in_* or out_ready.

## Configuration
- PSUM_SAT_EN
  - Defined: the accumulate add saturates as signed, to 2^(PSUM_WIDTH-1)-1 on overflow and -2^(PSUM_WIDTH-1) on underflow.
  - Not defined: wrap-around modulo 2^PSUM_WIDTH, identical to the plain adder.

## Test plan
- Basic accumulate: len_m1=3, pass_m1=1.
  - Stimulus: pass 0 sends 1,2,3,4; pass 1 sends 10,20,30,40.
  - Response: drain gives 11,22,33,44, out_last on 44, done one cycle later.
- Single pass and back-to-back jobs: len_m1=0, pass_m1=0, in_psum=-5.
  - Response: drain gives -5 with out_last=1.
  - A start asserted in the done cycle is accepted, and the next job drains its own data with no carry-over.
- Backpressure: 16 entries, 3 passes of value 1.
  - Stimulus: out_ready toggled randomly.
  - Response: every entry reads 3, out_psum stays stable while stalled, and exactly 16 handshakes occur.
- Overflow: PSUM_WIDTH=32, 0x7FFFFFFF then +1.
  - Without PSUM_SAT_EN: 0x80000000.
  - With PSUM_SAT_EN: 0x7FFFFFFF.
  - Likewise 0x80000000 + (-1) gives 0x7FFFFFFF without the macro and 0x80000000 with it.
- Protocol robustness:
  - start during ACC is ignored.
  - in_valid during IDLE or DRAIN gives in_ready=0 and no buffer change.
- Reset mid-job: assert rst_n=0 during ACC pass 1.
  - All outputs take their reset values asynchronously, before the next clock edge.
  - After release, a fresh job produces correct sums.
